// File: rtl/fm_op_state_ram.sv
// Per-operator state store for the FM synth engine: distributed RAM with a combinational
// read port, a registered write-through read port and a self-clearing sweep.
module fm_op_state_ram #(
    parameter int unsigned      DEPTH_LOG2 = 6,
    parameter int unsigned      WIDTH      = 26,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clear,
    output logic                  o_busy,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic                  wren,
    input  logic [WIDTH-1:0]      wrdata,
    output logic [WIDTH-1:0]      rddata,
    output logic [WIDTH-1:0]      rddata_q
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_CLEAR = 1'b1;

    localparam logic [DEPTH_LOG2-1:0] LAST_SLOT = {DEPTH_LOG2{1'b1}};
    localparam logic [DEPTH_LOG2-1:0] CNT_ONE   = DEPTH_LOG2'(1);

    logic                  state_q, state_d;
    logic [DEPTH_LOG2-1:0] clr_cnt_q, clr_cnt_d;
    logic [WIDTH-1:0]      rddata_d;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [WIDTH-1:0]      mem_rd;

    assign mem_rd = mem[idx];
    assign o_busy = (state_q == ST_CLEAR);
    assign rddata = o_busy ? INIT_VALUE : mem_rd;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_addr  = idx;
        mem_wdata = wrdata;
        rddata_d  = INIT_VALUE;

        if (state_q == ST_CLEAR) begin
            // The sweep owns the write port; user writes and clear requests are dropped.
            mem_we    = 1'b1;
            mem_addr  = clr_cnt_q;
            mem_wdata = INIT_VALUE;
            clr_cnt_d = clr_cnt_q + CNT_ONE;
            if (clr_cnt_q == LAST_SLOT) begin
                state_d = ST_IDLE;
            end
        end else begin
            mem_we = wren;
            if (i_clear) begin
                // Loading INIT_VALUE here keeps rddata_q at INIT_VALUE for the whole sweep.
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end else begin
                rddata_d = wren ? wrdata : mem_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            rddata_q  <= INIT_VALUE;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rddata_q  <= rddata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

endmodule
